// File: rtl/lsu_bus_controller_pkg.sv
// Load type encodings, controller state and alignment helpers for the LSU.
package lsu_bus_controller_pkg;
  import store_memory_encoder_pkg::*;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      STORE_H: return (offset == 2'd3);
      STORE_W: return (offset != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

  // Loads reuse the store lane pattern, so map each load type onto a store width.
  function automatic logic [1:0] load_width(input logic [2:0] ld_type);
    case (ld_type)
      LB, LBU: return STORE_B;
      LH, LHU: return STORE_H;
      default: return STORE_W;
    endcase
  endfunction

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/store_memory_encoder_pkg.sv
// Store width encodings shared by the store lane encoder and the LSU.
package store_memory_encoder_pkg;

  typedef enum logic [1:0] {
    STORE_B = 2'd0,
    STORE_H = 2'd1,
    STORE_W = 2'd2
  } store_type_e;

endpackage

// File: rtl/load_memory_decoder.sv
// Extracts the addressed byte/half/word from a bus read word and extends it.
module load_memory_decoder
  import lsu_bus_controller_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] dat_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = dat_i >> {offset_i, 3'b000};
    case (type_i)
      LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data_o = {24'h000000, shifted[7:0]};
      LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data_o = {16'h0000, shifted[15:0]};
      LW:      data_o = dat_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/store_memory_encoder.sv
// Shifts right-justified store data into its byte lanes and derives the lane
// enables; data_o lanes outside sel_o carry leftover bits and must be masked.
module store_memory_encoder
  import store_memory_encoder_pkg::*;
(
  input  logic [1:0]  store_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        misaligned_exception
);

  logic [3:0] mask;

  always_comb begin
    mask                 = 4'b0000;
    misaligned_exception = 1'b0;
    case (store_type_i)
      STORE_B: mask = 4'b0001;
      STORE_H: begin
        mask                 = 4'b0011;
        misaligned_exception = (offset_i == 2'd3);
      end
      STORE_W: begin
        mask                 = 4'b1111;
        misaligned_exception = (offset_i != 2'd0);
      end
      default: mask = 4'b0000;
    endcase
    sel_o  = mask << offset_i;
    data_o = data_i << {offset_i, 3'b000};
  end

endmodule

// File: rtl/lsu_bus_controller.sv
// Single-outstanding load/store sequencer onto a Wishbone-classic data bus.
// Define LSU_BUS_TIMEOUT_EN to bound the wait for ack/err by TIMEOUT_CYCLES.
module lsu_bus_controller
  import store_memory_encoder_pkg::*;
  import lsu_bus_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  lsu_state_e  state_q;
  logic        req_ready_q;
  logic        resp_valid_q, resp_misaligned_q, resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic        wb_cyc_q, wb_stb_q, wb_we_q;
  logic [31:0] wb_adr_q, wb_dat_q;
  logic [3:0]  wb_sel_q;
  logic        write_q;
  logic [2:0]  type_q;
  logic [1:0]  offset_q;

  logic [1:0]  enc_width;
  logic [31:0] enc_data;
  logic [3:0]  enc_sel;
  logic        enc_misaligned;
  logic        req_misaligned;
  logic        req_type_bad;
  logic [31:0] dec_data;
  logic        tmo_hit;

  assign enc_width      = req_write ? req_type[1:0] : load_width(req_type);
  assign req_misaligned = req_write ? enc_misaligned : is_misaligned(enc_width, req_addr[1:0]);
  assign req_type_bad   = req_write ? (req_type[1:0] == 2'b11) : (req_type > LHU);

  store_memory_encoder u_store_enc (
    .store_type_i         (enc_width),
    .offset_i             (req_addr[1:0]),
    .data_i               (req_wdata),
    .data_o               (enc_data),
    .sel_o                (enc_sel),
    .misaligned_exception (enc_misaligned)
  );

  load_memory_decoder u_load_dec (
    .type_i   (type_q),
    .offset_i (offset_q),
    .dat_i    (wb_dat_i),
    .data_o   (dec_data)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  logic [CW-1:0] tmo_cnt_q;
  logic [CW-1:0] tmo_cnt_inc;
  assign tmo_cnt_inc = tmo_cnt_q + CW'(1);
  assign tmo_hit     = (tmo_cnt_inc == CW'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      req_ready_q       <= 1'b1;
      resp_valid_q      <= 1'b0;
      resp_misaligned_q <= 1'b0;
      resp_fault_q      <= 1'b0;
      resp_rdata_q      <= '0;
      wb_cyc_q          <= 1'b0;
      wb_stb_q          <= 1'b0;
      wb_we_q           <= 1'b0;
      wb_adr_q          <= '0;
      wb_dat_q          <= '0;
      wb_sel_q          <= '0;
      write_q           <= 1'b0;
      type_q            <= '0;
      offset_q          <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_cnt_q         <= '0;
`endif
    end else begin
      resp_valid_q      <= 1'b0;
      resp_misaligned_q <= 1'b0;
      resp_fault_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            type_q      <= req_type;
            offset_q    <= req_addr[1:0];
            req_ready_q <= 1'b0;
            if (req_type_bad) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else if (req_misaligned) begin
              state_q           <= ST_RESP;
              resp_valid_q      <= 1'b1;
              resp_misaligned_q <= 1'b1;
            end else begin
              state_q  <= ST_BUS;
              wb_cyc_q <= 1'b1;
              wb_stb_q <= 1'b1;
              wb_we_q  <= req_write;
              wb_adr_q <= {req_addr[31:2], 2'b00};
              wb_sel_q <= enc_sel;
              wb_dat_q <= req_write ? (enc_data & sel_to_mask(enc_sel)) : '0;
`ifdef LSU_BUS_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        ST_BUS: begin
          // err outranks ack; a timeout only counts when neither arrived.
          if (wb_err_i || wb_ack_i || tmo_hit) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= wb_err_i || !wb_ack_i;
            resp_rdata_q <= (wb_ack_i && !wb_err_i && !write_q) ? dec_data : '0;
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            wb_sel_q     <= '0;
          end
`ifdef LSU_BUS_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_inc;
`endif
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_rdata_q <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_fault      = resp_fault_q;
  assign wb_cyc_o        = wb_cyc_q;
  assign wb_stb_o        = wb_stb_q;
  assign wb_we_o         = wb_we_q;
  assign wb_adr_o        = wb_adr_q;
  assign wb_dat_o        = wb_dat_q;
  assign wb_sel_o        = wb_sel_q;

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Self-checking bench for lsu_bus_controller: vector table plus a response
// scoreboard, with hand sequences for reset, idle acks and the bus timeout.
module tb_lsu_bus_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  lsu_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  typedef struct {
    logic        write;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdin;
    int unsigned dly;
    logic        ack;
    logic        err;
    logic        bus;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic mis, input logic flt);
    exp_t e;
    e.rdata = rdata;
    e.mis   = mis;
    e.flt   = flt;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.flt});
      end
    end
  end

  // Called at a negedge with the controller idle; returns at the negedge after RESP.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_type  = v.typ;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    push_exp(v.rdata, v.mis, v.flt);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'hDEAD_0000;
    chk($sformatf("v%0d_ready_low", idx), {31'd0, req_ready}, 32'd0);
    if (v.bus) begin
      chk($sformatf("v%0d_cyc", idx), {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
      chk($sformatf("v%0d_we", idx), {31'd0, wb_we_o}, {31'd0, v.write});
      chk($sformatf("v%0d_adr", idx), wb_adr_o, v.adr);
      chk($sformatf("v%0d_sel", idx), {28'd0, wb_sel_o}, {28'd0, v.sel});
      if (v.write) chk($sformatf("v%0d_dat", idx), wb_dat_o, v.dat);
      for (int unsigned w = 0; w < v.dly; w++) begin
        @(negedge clk);
        chk($sformatf("v%0d_wait_cyc", idx), {31'd0, wb_cyc_o}, 32'd1);
        chk($sformatf("v%0d_wait_adr", idx), wb_adr_o, v.adr);
        chk($sformatf("v%0d_wait_resp", idx), {31'd0, resp_valid}, 32'd0);
      end
      wb_ack_i = v.ack;
      wb_err_i = v.err;
      wb_dat_i = v.rdin;
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h5555_AAAA;
      chk($sformatf("v%0d_cyc_drop", idx), {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    end else begin
      chk($sformatf("v%0d_no_cyc", idx), {31'd0, wb_cyc_o}, 32'd0);
    end
    chk($sformatf("v%0d_resp_valid", idx), {31'd0, resp_valid}, 32'd1);
    chk($sformatf("v%0d_resp_ready", idx), {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_resp_pulse", idx), {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    vec_t t;
    int unsigned cnt;
    logic stayed;

    //        wr typ   addr          wdata         rdin          dly ack err bus adr           sel      dat           rdata         mis flt
    vecs[0]  = '{1, 3'd1, 32'h0000_1001, 32'hAAAA_1234, 32'h0,        0, 1, 0, 1, 32'h0000_1000, 4'b0110, 32'h0012_3400, 32'h0,        0, 0};
    vecs[1]  = '{0, 3'd0, 32'h0000_2003, 32'h0,        32'h80FF_FFFF, 3, 1, 0, 1, 32'h0000_2000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 0};
    vecs[2]  = '{0, 3'd3, 32'h0000_2003, 32'h0,        32'h80FF_FFFF, 3, 1, 0, 1, 32'h0000_2000, 4'b1000, 32'h0,        32'h0000_0080, 0, 0};
    vecs[3]  = '{1, 3'd2, 32'h0000_2002, 32'h1111_1111, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[4]  = '{0, 3'd1, 32'h0000_2003, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[5]  = '{0, 3'd2, 32'h0000_0000, 32'h0,        32'h1234_5678, 0, 1, 1, 1, 32'h0000_0000, 4'b1111, 32'h0,        32'h0,        0, 1};
    vecs[6]  = '{0, 3'd1, 32'h0000_3002, 32'h0,        32'h9ABC_1234, 1, 1, 0, 1, 32'h0000_3000, 4'b1100, 32'h0,        32'hFFFF_9ABC, 0, 0};
    vecs[7]  = '{0, 3'd4, 32'h0000_3001, 32'h0,        32'h9ABC_1234, 0, 1, 0, 1, 32'h0000_3000, 4'b0110, 32'h0,        32'h0000_BC12, 0, 0};
    vecs[8]  = '{0, 3'd2, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 2, 1, 0, 1, 32'h0000_4000, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 0};
    vecs[9]  = '{1, 3'd0, 32'h0000_5003, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 1, 0, 1, 32'h0000_5000, 4'b1000, 32'hA500_0000, 32'h0,        0, 0};
    vecs[10] = '{1, 3'd2, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,        2, 1, 0, 1, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0};
    vecs[11] = '{1, 3'd4, 32'h0000_7002, 32'hFFFF_FFEE, 32'h0,        0, 1, 0, 1, 32'h0000_7000, 4'b0100, 32'h00EE_0000, 32'h0,        0, 0};
    vecs[12] = '{0, 3'd5, 32'h0000_8000, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1};
    vecs[13] = '{1, 3'd3, 32'h0000_8000, 32'h0000_00FF, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1};
    vecs[14] = '{1, 3'd1, 32'h0000_9002, 32'h0000_BEEF, 32'h0,        1, 0, 1, 1, 32'h0000_9000, 4'b1100, 32'hBEEF_0000, 32'h0,        0, 1};
    vecs[15] = '{0, 3'd0, 32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 1, 0, 1, 32'h0000_7000, 4'b0010, 32'h0,        32'h0000_007F, 0, 0};
    vecs[16] = '{0, 3'd4, 32'h0000_7003, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[17] = '{0, 3'd7, 32'h0000_7000, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_misaligned, resp_fault}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wb_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_wb_adr", wb_adr_o, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_wb_sel", {28'd0, wb_sel_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // ack/err while idle must not produce a response
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ack_resp", {31'd0, resp_valid}, 32'd0);
      chk("idle_ack_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;

    // reset while the bus cycle is open
    req_valid = 1'b1; req_write = 1'b0; req_type = 3'd2; req_addr = 32'h0000_A000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rst_cyc_before", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cyc_async", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_vec(vecs[8], 100);

`ifdef LSU_BUS_TIMEOUT_EN
    push_exp(32'h0, 1'b0, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_type = 3'd2; req_addr = 32'h0000_B000;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (resp_valid !== 1'b1 && cnt < 20) begin
      chk("tmo_cyc_high", {31'd0, wb_cyc_o}, 32'd1);
      cnt++;
      @(negedge clk);
    end
    chk("tmo_bus_cycles", cnt, 32'd4);
    chk("tmo_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
`else
    push_exp(32'h0BAD_F00D, 1'b0, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_type = 3'd2; req_addr = 32'h0000_B000;
    @(negedge clk);
    req_valid = 1'b0;
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || resp_valid !== 1'b0) stayed = 1'b0;
      @(negedge clk);
    end
    chk("no_tmo_stays_bus", {31'd0, stayed}, 32'd1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_F00D;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("no_tmo_resp", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);
`endif

    // a final back-to-back pair after the long sequence
    t = vecs[0];
    run_vec(t, 200);
    run_vec(vecs[15], 201);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
